// File: rtl/riscv_core_dcache_pkg.sv
// Shared D-cache definitions: block geometry, address field positions and
// the memory responder state encoding.
package riscv_core_dcache_pkg;

  localparam int BLOCK_BYTES     = 32;
  localparam int WORDS_PER_BLOCK = 4;

  // Cache address fields (128 sets x 32 B blocks)
  localparam int BLOCK_OFFSET_W   = $clog2(BLOCK_BYTES);
  localparam int BLOCK_OFFSET_LSB = 0;
  localparam int INDEX_W          = 7;
  localparam int INDEX_LSB        = BLOCK_OFFSET_LSB + BLOCK_OFFSET_W;
  localparam int TAG_LSB          = INDEX_LSB + INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_WAIT,
    WR_DONE
  } dcache_mem_resp_state_e;

endpackage

// File: rtl/riscv_core_dcache_mem_array.sv
// Backing word array for the D-cache memory responder.
//   clk       : write clock (array has no reset)
//   wr_en     : commit byte-strobed word write this edge
//   wr_idx    : word index, wr_data / wr_strb : word and byte enables
//   rd_blk    : aligned block index, rd_block : combinational block read,
//               word 0 in the low DATA_W bits
module riscv_core_dcache_mem_array #(
  parameter int DATA_W        = 64,
  parameter int WORDS_PER_BLK = 4,
  parameter int DEPTH         = 4096,
  parameter int IDX_W         = $clog2(DEPTH),
  parameter int OFF_W         = $clog2(WORDS_PER_BLK),
  parameter int BLK_IDX_W     = IDX_W - OFF_W
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_idx,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic [DATA_W/8-1:0]             wr_strb,
  input  logic [BLK_IDX_W-1:0]            rd_blk,
  output logic [DATA_W*WORDS_PER_BLK-1:0] rd_block
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int n = 0; n < DATA_W/8; n++)
        if (wr_strb[n]) mem[wr_idx][8*n +: 8] <= wr_data[8*n +: 8];
    end
  end

  for (genvar w = 0; w < WORDS_PER_BLK; w++) begin : g_rd
    assign rd_block[w*DATA_W +: DATA_W] = mem[{rd_blk, OFF_W'(w)}];
  end

endmodule

// File: rtl/riscv_core_dcache_mem_responder.sv
// Memory-side responder for the D-cache refill / write-through interface.
// Serves aligned block refills and byte-strobed word stores from an internal
// array with fixed response latencies. One transaction outstanding; a store
// wins over a simultaneous refill so write-through data lands first.
//   i_clk, i_rst_n                : clock, async active-low reset
//   i_mem_read_req / _address     : refill request (level, held until done)
//   o_mem_read_done / o_block_from_axi : done pulse and registered block
//   i_mem_write_valid / _address / _data / _strobe : store request
//   o_mem_write_done              : store committed pulse
//   o_busy                        : any state other than IDLE
module riscv_core_dcache_mem_responder
  import riscv_core_dcache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int AXI_DATA_WIDTH  = 256,
  parameter int MEM_DEPTH_WORDS = 4096,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]        i_mem_read_address,
  output logic                         o_mem_read_done,
  output logic [AXI_DATA_WIDTH-1:0]    o_block_from_axi,
  input  logic                         i_mem_write_valid,
  input  logic [ADDR_WIDTH-1:0]        i_mem_write_address,
  input  logic [CORE_DATA_WIDTH-1:0]   i_mem_write_data,
  input  logic [CORE_DATA_WIDTH/8-1:0] i_mem_write_strobe,
  output logic                         o_mem_write_done,
  output logic                         o_busy
);

  localparam int STRB_W     = CORE_DATA_WIDTH / 8;
  localparam int WORD_OFF_W = $clog2(STRB_W);
  localparam int WPB        = AXI_DATA_WIDTH / CORE_DATA_WIDTH;
  localparam int BLK_OFF_W  = $clog2(AXI_DATA_WIDTH / 8);
  localparam int IDX_W      = $clog2(MEM_DEPTH_WORDS);
  localparam int BLK_IDX_W  = IDX_W - $clog2(WPB);
  localparam int MAX_LAT    = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W      = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  dcache_mem_resp_state_e state;
  logic [CNT_W-1:0]           cnt;
  logic                       rd_armed, wr_armed;
  logic [BLK_IDX_W-1:0]       rd_blk_q;
  logic [IDX_W-1:0]           wr_idx_q;
  logic [CORE_DATA_WIDTH-1:0] wr_data_q;
  logic [STRB_W-1:0]          wr_strb_q;

  logic                       wr_acc, rd_acc, wr_fin, rd_fin, in_idle;
  logic [IDX_W-1:0]           arr_wr_idx;
  logic [CORE_DATA_WIDTH-1:0] arr_wr_data;
  logic [STRB_W-1:0]          arr_wr_strb;
  logic [BLK_IDX_W-1:0]       arr_rd_blk;
  logic [AXI_DATA_WIDTH-1:0]  arr_block;
  logic                       unused_addr_bits;

  // Upper address bits wrap; low offset bits are don't-care.
  assign unused_addr_bits = ^{i_mem_read_address, i_mem_write_address};

  assign in_idle = (state == IDLE);
  assign wr_acc  = in_idle && i_mem_write_valid && wr_armed;
  assign rd_acc  = in_idle && !wr_acc && i_mem_read_req && rd_armed;

  // cnt holds edges remaining until DONE entry, counting the accept edge.
  // DONE is entered on the edge where it would reach zero, so done is high in
  // the cycle after edge accept+LATENCY-1. A latency of 1 skips WAIT entirely.
  assign wr_fin = (wr_acc && WRITE_LATENCY == 1) || (state == WR_WAIT && cnt == CNT_W'(1));
  assign rd_fin = (rd_acc && READ_LATENCY == 1)  || (state == RD_WAIT && cnt == CNT_W'(1));

  // Captured request except when finishing straight out of IDLE.
  assign arr_wr_idx  = in_idle ? i_mem_write_address[IDX_W+WORD_OFF_W-1:WORD_OFF_W] : wr_idx_q;
  assign arr_wr_data = in_idle ? i_mem_write_data : wr_data_q;
  assign arr_wr_strb = in_idle ? i_mem_write_strobe : wr_strb_q;
  assign arr_rd_blk  = in_idle ? i_mem_read_address[BLK_OFF_W+BLK_IDX_W-1:BLK_OFF_W] : rd_blk_q;

  riscv_core_dcache_mem_array #(
    .DATA_W(CORE_DATA_WIDTH), .WORDS_PER_BLK(WPB), .DEPTH(MEM_DEPTH_WORDS)
  ) u_array (
    .clk(i_clk), .wr_en(wr_fin), .wr_idx(arr_wr_idx), .wr_data(arr_wr_data),
    .wr_strb(arr_wr_strb), .rd_blk(arr_rd_blk), .rd_block(arr_block)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      rd_armed         <= 1'b1;
      wr_armed         <= 1'b1;
      rd_blk_q         <= '0;
      wr_idx_q         <= '0;
      wr_data_q        <= '0;
      wr_strb_q        <= '0;
      o_mem_read_done  <= 1'b0;
      o_mem_write_done <= 1'b0;
      o_busy           <= 1'b0;
      o_block_from_axi <= '0;
    end else begin
      o_mem_read_done  <= 1'b0;
      o_mem_write_done <= 1'b0;
      // Re-arm once the requester has dropped its level request.
      if (!i_mem_read_req)    rd_armed <= 1'b1;
      if (!i_mem_write_valid) wr_armed <= 1'b1;
      if (wr_fin) begin
        state            <= WR_DONE;
        o_mem_write_done <= 1'b1;
        wr_armed         <= 1'b0;
        o_busy           <= 1'b1;
      end else if (rd_fin) begin
        state            <= RD_DONE;
        o_mem_read_done  <= 1'b1;
        o_block_from_axi <= arr_block;
        rd_armed         <= 1'b0;
        o_busy           <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (wr_acc) begin
              state     <= WR_WAIT;
              cnt       <= WR_LOAD;
              wr_idx_q  <= arr_wr_idx;
              wr_data_q <= i_mem_write_data;
              wr_strb_q <= i_mem_write_strobe;
              o_busy    <= 1'b1;
            end else if (rd_acc) begin
              state    <= RD_WAIT;
              cnt      <= RD_LOAD;
              rd_blk_q <= arr_rd_blk;
              o_busy   <= 1'b1;
            end
          end
          RD_WAIT, WR_WAIT: cnt <= cnt - 1'b1;
          RD_DONE, WR_DONE: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_dcache_mem_responder.sv
module tb_riscv_core_dcache_mem_responder;

  localparam int RL = 4;
  localparam int WL = 2;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_mem_read_req = 1'b0;
  logic [63:0]  i_mem_read_address = '0;
  logic         o_mem_read_done;
  logic [255:0] o_block_from_axi;
  logic         i_mem_write_valid = 1'b0;
  logic [63:0]  i_mem_write_address = '0;
  logic [63:0]  i_mem_write_data = '0;
  logic [7:0]   i_mem_write_strobe = '0;
  logic         o_mem_write_done;
  logic         o_busy;

  always #5 i_clk = ~i_clk;

  riscv_core_dcache_mem_responder #(
    .ADDR_WIDTH(64), .CORE_DATA_WIDTH(64), .AXI_DATA_WIDTH(256),
    .MEM_DEPTH_WORDS(4096), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_mem_read_req(i_mem_read_req), .i_mem_read_address(i_mem_read_address),
    .o_mem_read_done(o_mem_read_done), .o_block_from_axi(o_block_from_axi),
    .i_mem_write_valid(i_mem_write_valid), .i_mem_write_address(i_mem_write_address),
    .i_mem_write_data(i_mem_write_data), .i_mem_write_strobe(i_mem_write_strobe),
    .o_mem_write_done(o_mem_write_done), .o_busy(o_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference memory: 4096 words, word index = byte address / 8 modulo 4096.
  logic [63:0] model_mem [4096];

  function automatic void model_write(input logic [63:0] a, input logic [63:0] d,
                                      input logic [7:0] s);
    int i;
    i = int'((a >> 3) % 4096);
    for (int n = 0; n < 8; n++)
      if (s[n]) model_mem[i][8*n +: 8] = d[8*n +: 8];
  endfunction

  function automatic logic [255:0] model_block(input logic [63:0] a);
    int b;
    b = int'(((a >> 5) % 1024) * 4);
    return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
  endfunction

  function automatic logic [63:0] mk_addr(input int blk, input int w);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[14:5] = 10'(blk);
    r[4:3]  = 2'(w);
    return r;
  endfunction

  // lat = number of rising edges from the accept edge (1) to the edge after
  // which done is seen high; -1 if it never came.
  task automatic drive_write(input logic [63:0] a, input logic [63:0] d,
                             input logic [7:0] s, output int lat);
    @(negedge i_clk);
    i_mem_write_address = a; i_mem_write_data = d; i_mem_write_strobe = s;
    i_mem_write_valid = 1'b1;
    lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge i_clk); @(negedge i_clk);
      if (o_mem_write_done) begin lat = c; break; end
    end
    i_mem_write_valid = 1'b0;
  endtask

  task automatic drive_read(input logic [63:0] a, output int lat, output logic [255:0] blk);
    @(negedge i_clk);
    i_mem_read_address = a; i_mem_read_req = 1'b1;
    lat = -1; blk = '0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge i_clk); @(negedge i_clk);
      if (o_mem_read_done) begin lat = c; blk = o_block_from_axi; break; end
    end
    i_mem_read_req = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1;
    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    vectors++; if (o_mem_read_done !== 1'b0) begin miscompares++; $display("FAIL reset_rdone: got %b want 0", o_mem_read_done); end
    vectors++; if (o_mem_write_done !== 1'b0) begin miscompares++; $display("FAIL reset_wdone: got %b want 0", o_mem_write_done); end
    vectors++; if (o_block_from_axi !== 256'd0) begin miscompares++; $display("FAIL reset_block: got %h want 0", o_block_from_axi); end
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_refill_basic();
    int lat; logic [255:0] blk;
    logic [63:0] pat [4];
    pat[0] = 64'h1111111111111111; pat[1] = 64'h2222222222222222;
    pat[2] = 64'h3333333333333333; pat[3] = 64'h4444444444444444;
    for (int w = 0; w < 4; w++) begin
      drive_write(64'(w * 8), pat[w], 8'hFF, lat);
      model_write(64'(w * 8), pat[w], 8'hFF);
      vectors++; if (lat !== WL) begin miscompares++; $display("FAIL preload_wlat: got %0d want %0d", lat, WL); end
    end
    drive_read(64'h0, lat, blk);
    vectors++; if (lat !== RL) begin miscompares++; $display("FAIL refill_lat: got %0d want %0d", lat, RL); end
    vectors++; if (blk !== {pat[3], pat[2], pat[1], pat[0]})
      begin miscompares++; $display("FAIL refill_block: got %h want %h", blk, {pat[3], pat[2], pat[1], pat[0]}); end
  endtask

  task automatic test_strobe_merge();
    int lat; logic [255:0] blk; logic [63:0] d;
    for (int w = 0; w < 4; w++) begin
      d = (w == 1) ? 64'hFFFFFFFF_FFFFFFFF : {$urandom, $urandom};
      drive_write(64'h20 + 64'(w * 8), d, 8'hFF, lat);
      model_write(64'h20 + 64'(w * 8), d, 8'hFF);
    end
    drive_write(64'h28, 64'hDEADBEEF_CAFEF00D, 8'h0F, lat);
    model_write(64'h28, 64'hDEADBEEF_CAFEF00D, 8'h0F);
    vectors++; if (lat !== WL) begin miscompares++; $display("FAIL merge_wlat: got %0d want %0d", lat, WL); end
    drive_read(64'h20, lat, blk);
    vectors++; if (blk[127:64] !== 64'hFFFFFFFF_CAFEF00D)
      begin miscompares++; $display("FAIL merge_word1: got %h want ffffffffcafef00d", blk[127:64]); end
    vectors++; if (blk !== model_block(64'h20))
      begin miscompares++; $display("FAIL merge_block: got %h want %h", blk, model_block(64'h20)); end
    // Zero strobe: completes, memory untouched.
    drive_write(64'h30, {$urandom, $urandom}, 8'h00, lat);
    vectors++; if (lat !== WL) begin miscompares++; $display("FAIL zstrb_wlat: got %0d want %0d", lat, WL); end
    drive_read(64'h20, lat, blk);
    vectors++; if (blk !== model_block(64'h20))
      begin miscompares++; $display("FAIL zstrb_block: got %h want %h", blk, model_block(64'h20)); end
  endtask

  task automatic test_simultaneous();
    int wcyc, rcyc; logic [255:0] blk; logic [63:0] d; logic [7:0] s;
    d = {$urandom, $urandom}; s = 8'($urandom_range(1, 255));
    @(negedge i_clk);
    i_mem_write_address = 64'h38; i_mem_write_data = d; i_mem_write_strobe = s;
    i_mem_write_valid = 1'b1;
    i_mem_read_address = 64'h20; i_mem_read_req = 1'b1;
    model_write(64'h38, d, s);
    wcyc = -1; rcyc = -1; blk = '0;
    for (int c = 1; c <= 64 && rcyc < 0; c++) begin
      @(posedge i_clk); @(negedge i_clk);
      if (o_mem_write_done && wcyc < 0) begin wcyc = c; i_mem_write_valid = 1'b0; end
      if (o_mem_read_done && rcyc < 0) begin rcyc = c; blk = o_block_from_axi; i_mem_read_req = 1'b0; end
    end
    i_mem_write_valid = 1'b0; i_mem_read_req = 1'b0;
    vectors++; if (wcyc !== WL) begin miscompares++; $display("FAIL simul_wdone: got %0d want %0d", wcyc, WL); end
    vectors++; if (rcyc !== WL + 1 + RL) begin miscompares++; $display("FAIL simul_rdone: got %0d want %0d", rcyc, WL + 1 + RL); end
    vectors++; if (blk !== model_block(64'h20))
      begin miscompares++; $display("FAIL simul_block: got %h want %h", blk, model_block(64'h20)); end
  endtask

  task automatic test_hold_request();
    int lat, pulses; logic [255:0] blk;
    @(negedge i_clk);
    i_mem_read_address = 64'h8; i_mem_read_req = 1'b1;
    pulses = 0; lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge i_clk); @(negedge i_clk);
      if (o_mem_read_done) begin lat = c; pulses++; break; end
    end
    repeat (10) begin
      @(posedge i_clk); @(negedge i_clk);
      if (o_mem_read_done) pulses++;
    end
    i_mem_read_req = 1'b0;
    vectors++; if (lat !== RL) begin miscompares++; $display("FAIL hold_lat: got %0d want %0d", lat, RL); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    drive_read(64'h8, lat, blk);
    vectors++; if (lat !== RL) begin miscompares++; $display("FAIL rearm_lat: got %0d want %0d", lat, RL); end
    vectors++; if (blk !== model_block(64'h0))
      begin miscompares++; $display("FAIL rearm_block: got %h want %h", blk, model_block(64'h0)); end
  endtask

  task automatic test_reset_mid();
    int lat, pulses; logic [255:0] blk;
    @(negedge i_clk);
    i_mem_read_address = 64'h0; i_mem_read_req = 1'b1;
    repeat (2) begin @(posedge i_clk); @(negedge i_clk); end
    i_rst_n = 1'b0; i_mem_read_req = 1'b0;
    #1;
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
    @(negedge i_clk); i_rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin @(posedge i_clk); @(negedge i_clk); if (o_mem_read_done) pulses++; end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rstmid_nodone: got %0d pulses want 0", pulses); end
    // Store abandoned before its commit edge must leave memory unchanged.
    @(negedge i_clk);
    i_mem_write_address = 64'h10; i_mem_write_data = ~model_mem[2];
    i_mem_write_strobe = 8'hFF; i_mem_write_valid = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL rstwr_busy: got %b want 1", o_busy); end
    i_rst_n = 1'b0; i_mem_write_valid = 1'b0;
    @(negedge i_clk); i_rst_n = 1'b1;
    drive_read(64'h0, lat, blk);
    vectors++; if (lat !== RL) begin miscompares++; $display("FAIL rstmid_lat: got %0d want %0d", lat, RL); end
    vectors++; if (blk !== model_block(64'h0))
      begin miscompares++; $display("FAIL rstwr_block: got %h want %h", blk, model_block(64'h0)); end
  endtask

  task automatic test_wrap();
    int lat; logic [255:0] blk;
    drive_read(64'h1_0000_0020, lat, blk);
    vectors++; if (lat !== RL) begin miscompares++; $display("FAIL wrap_lat: got %0d want %0d", lat, RL); end
    vectors++; if (blk !== model_block(64'h20))
      begin miscompares++; $display("FAIL wrap_block: got %h want %h", blk, model_block(64'h20)); end
  endtask

  task automatic test_random();
    int lat; logic [255:0] blk; logic [63:0] a, d; logic [7:0] s;
    int bk [8];
    for (int i = 0; i < 8; i++) begin
      bk[i] = int'($urandom_range(2, 1023));
      for (int w = 0; w < 4; w++) begin
        a = mk_addr(bk[i], w); d = {$urandom, $urandom};
        drive_write(a, d, 8'hFF, lat);
        model_write(a, d, 8'hFF);
      end
    end
    for (int k = 0; k < 40; k++) begin
      a = mk_addr(bk[$urandom_range(0, 7)], int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 0) begin
        d = {$urandom, $urandom}; s = 8'($urandom);
        drive_write(a, d, s, lat);
        model_write(a, d, s);
        vectors++; if (lat !== WL) begin miscompares++; $display("FAIL rand_wlat[%0d]: got %0d want %0d", k, lat, WL); end
      end else begin
        drive_read(a, lat, blk);
        vectors++; if (lat !== RL) begin miscompares++; $display("FAIL rand_rlat[%0d]: got %0d want %0d", k, lat, RL); end
        vectors++; if (blk !== model_block(a))
          begin miscompares++; $display("FAIL rand_block[%0d] addr %h: got %h want %h", k, a, blk, model_block(a)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_refill_basic();
    test_strobe_merge();
    test_simultaneous();
    test_hold_request();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
